// File: rtl/rfg_axis_protocol_param_fifo_pkg.sv
// Shared types and helpers for the rfg AXIS protocol FIFO.
//  fifo_depth()  : entry count for a given address width
//  margin_ok()   : legal range check for almost-full/almost-empty margins
//  fifo_status_t : status flags in status-register bit order
package rfg_axis_protocol_fifo_pkg;

  function automatic int fifo_depth(input int awidth);
    return 1 << awidth;
  endfunction

  function automatic bit margin_ok(input int margin, input int depth);
    return (margin >= 1) && (margin <= depth - 1);
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/rfg_axis_protocol_param_fifo_if.sv
// FIFO request/status bundle.
//  master : producer/consumer side (drives flush/write/read)
//  slave  : FIFO side (drives read_value, count and flags)
interface rfg_axis_protocol_param_fifo_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 2
);
  logic              flush;
  logic              write;
  logic [DWIDTH-1:0] write_value;
  logic              read;
  logic [DWIDTH-1:0] read_value;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              almost_empty;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, write, write_value, read,
    input  read_value, full, almost_full, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, write, write_value, read,
    output read_value, full, almost_full, empty, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/rfg_axis_protocol_param_fifo_mem.sv
// FIFO storage: DEPTH x DWIDTH registers, one synchronous write port and one
// asynchronous read port. Not reset; stale words are masked by the empty flag.
//  clk      : write clock
//  we_i     : write enable
//  waddr_i  : write address
//  wdata_i  : write data
//  raddr_i  : read address
//  rdata_o  : read data (combinational)
module rfg_axis_protocol_fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rfg_axis_protocol_param_fifo.sv
// First-word-fall-through FIFO with occupancy count, almost-full/empty margins,
// synchronous flush and sticky overflow/underflow flags.
//  clk  : clock, rising edge
//  res  : asynchronous active-high reset
//  bus  : request inputs (flush/write/write_value/read) and status outputs
//         (read_value, count, full/almost_full/empty/almost_empty,
//         overflow/underflow)
module rfg_axis_protocol_param_fifo
  import rfg_axis_protocol_fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 2,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic                   clk,
  input  logic                   res,
  rfg_axis_protocol_param_fifo_if.slave bus
);
  localparam int DEPTH = fifo_depth(AWIDTH);
  localparam int CW    = AWIDTH + 1;

  localparam fifo_status_t STATUS_RST = '{
    full: 1'b0, almost_full: 1'b0, empty: 1'b1, almost_empty: 1'b1,
    overflow: 1'b0, underflow: 1'b0
  };

  if (!margin_ok(AF_MARGIN, DEPTH)) begin : g_af_bad
    $error("AF_MARGIN must be within 1..DEPTH-1");
  end
  if (!margin_ok(AE_MARGIN, DEPTH)) begin : g_ae_bad
    $error("AE_MARGIN must be within 1..DEPTH-1");
  end

  logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  fifo_status_t      status_q, status_d;
  logic              rd_acc, wr_acc, mem_we;

  always_comb begin
    // A read at full frees a slot, so a same-cycle write still fits.
    rd_acc   = bus.read & ~status_q.empty;
    wr_acc   = bus.write & (~status_q.full | rd_acc);
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      mem_we  = wr_acc;
      if (wr_acc) wptr_d = wptr_q + AWIDTH'(1);
      if (rd_acc) rptr_d = rptr_q + AWIDTH'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end
    // Flags decode the next count so they move on the same edge as count.
    status_d.full         = (count_d == CW'(DEPTH));
    status_d.almost_full  = (count_d >= CW'(DEPTH - AF_MARGIN));
    status_d.empty        = (count_d == '0);
    status_d.almost_empty = (count_d <= CW'(AE_MARGIN));
    status_d.overflow     = ~bus.flush & (status_q.overflow  | (bus.write & ~wr_acc));
    status_d.underflow    = ~bus.flush & (status_q.underflow | (bus.read & status_q.empty));
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      status_q <= STATUS_RST;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  rfg_axis_protocol_fifo_mem #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.write_value),
    .raddr_i (rptr_q),
    .rdata_o (bus.read_value)
  );

  assign bus.count        = count_q;
  assign bus.full         = status_q.full;
  assign bus.almost_full  = status_q.almost_full;
  assign bus.empty        = status_q.empty;
  assign bus.almost_empty = status_q.almost_empty;
  assign bus.overflow     = status_q.overflow;
  assign bus.underflow    = status_q.underflow;
endmodule

// File: tb/tb_rfg_axis_protocol_param_fifo.sv
module tb_rfg_axis_protocol_param_fifo;
  logic clk = 1'b0;
  logic res;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rfg_axis_protocol_param_fifo_if #(.DWIDTH(8),  .AWIDTH(2)) fa ();
  rfg_axis_protocol_param_fifo_if #(.DWIDTH(16), .AWIDTH(3)) fb ();

  rfg_axis_protocol_param_fifo #(.DWIDTH(8), .AWIDTH(2), .AF_MARGIN(1), .AE_MARGIN(1)) dut_a (
    .clk(clk), .res(res), .bus(fa)
  );
  rfg_axis_protocol_param_fifo #(.DWIDTH(16), .AWIDTH(3), .AF_MARGIN(2), .AE_MARGIN(2)) dut_b (
    .clk(clk), .res(res), .bus(fb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic w, input logic [7:0] v, input logic r, input logic f);
    fa.write = w; fa.write_value = v; fa.read = r; fa.flush = f;
  endtask

  task automatic chk_a_flags(input string tag, input int cnt, input logic fu, input logic af,
                             input logic em, input logic ae);
    chk({tag, ".count"}, 32'(fa.count), cnt);
    chk({tag, ".full"}, 32'(fa.full), 32'(fu));
    chk({tag, ".afull"}, 32'(fa.almost_full), 32'(af));
    chk({tag, ".empty"}, 32'(fa.empty), 32'(em));
    chk({tag, ".aempty"}, 32'(fa.almost_empty), 32'(ae));
  endtask

  initial begin
    logic [15:0] q[$];
    int pushed, popped, cyc;
    logic w, r, rd, wr;
    logic [15:0] v;

    res = 1'b1;
    drv_a(0, 8'h00, 0, 0);
    fb.write = 0; fb.write_value = '0; fb.read = 0; fb.flush = 0;
    #12;
    // reset state
    chk_a_flags("rst", 0, 0, 0, 1, 1);
    chk("rst.ovf", 32'(fa.overflow), 0);
    chk("rst.unf", 32'(fa.underflow), 0);
    chk("rst_b.empty", 32'(fb.empty), 1);
    @(negedge clk) res = 1'b0;

    // 1. fill then drain
    drv_a(1, 8'h11, 0, 0); step(); chk_a_flags("f1", 1, 0, 0, 0, 1);
    chk("f1.rv", 32'(fa.read_value), 32'h11);
    drv_a(1, 8'h22, 0, 0); step(); chk_a_flags("f2", 2, 0, 0, 0, 0);
    drv_a(1, 8'h33, 0, 0); step(); chk_a_flags("f3", 3, 0, 1, 0, 0);
    drv_a(1, 8'h44, 0, 0); step(); chk_a_flags("f4", 4, 1, 1, 0, 0);
    drv_a(0, 8'h00, 1, 0); step(); chk_a_flags("d1", 3, 0, 1, 0, 0);
    chk("d1.rv", 32'(fa.read_value), 32'h22);
    step(); chk_a_flags("d2", 2, 0, 0, 0, 0); chk("d2.rv", 32'(fa.read_value), 32'h33);
    step(); chk_a_flags("d3", 1, 0, 0, 0, 1); chk("d3.rv", 32'(fa.read_value), 32'h44);
    step(); chk_a_flags("d4", 0, 0, 0, 1, 1);

    // 2. simultaneous read/write at full
    drv_a(1, 8'h11, 0, 0); step();
    drv_a(1, 8'h22, 0, 0); step();
    drv_a(1, 8'h33, 0, 0); step();
    drv_a(1, 8'h44, 0, 0); step();
    drv_a(1, 8'h55, 1, 0); step();
    chk_a_flags("rw", 4, 1, 1, 0, 0);
    chk("rw.ovf", 32'(fa.overflow), 0);
    chk("rw.rv", 32'(fa.read_value), 32'h22);
    drv_a(0, 8'h00, 1, 0); step(); chk("rw.rv2", 32'(fa.read_value), 32'h33);
    step(); chk("rw.rv3", 32'(fa.read_value), 32'h44);
    step(); chk("rw.rv4", 32'(fa.read_value), 32'h55);
    step(); chk("rw.empty", 32'(fa.empty), 1);

    // 3. overflow and underflow stickiness
    drv_a(1, 8'h61, 0, 0); step();
    drv_a(1, 8'h62, 0, 0); step();
    drv_a(1, 8'h63, 0, 0); step();
    drv_a(1, 8'h64, 0, 0); step();
    drv_a(1, 8'h99, 0, 0); step();
    chk("ovf.set", 32'(fa.overflow), 1);
    chk("ovf.count", 32'(fa.count), 4);
    chk("ovf.rv", 32'(fa.read_value), 32'h61);
    drv_a(0, 8'h00, 1, 0); step(); chk("ovf.rv2", 32'(fa.read_value), 32'h62);
    step(); chk("ovf.rv3", 32'(fa.read_value), 32'h63);
    step(); chk("ovf.rv4", 32'(fa.read_value), 32'h64);
    step(); chk("ovf.empty", 32'(fa.empty), 1);
    chk("unf.pre", 32'(fa.underflow), 0);
    step();
    chk("unf.set", 32'(fa.underflow), 1);
    chk("unf.count", 32'(fa.count), 0);
    drv_a(0, 8'h00, 0, 0); step(); step();
    chk("ovf.hold", 32'(fa.overflow), 1);
    chk("unf.hold", 32'(fa.underflow), 1);
    // wptr stayed put: next word lands where the head points
    drv_a(1, 8'hA5, 0, 0); step(); chk("ovf.wptr", 32'(fa.read_value), 32'hA5);
    drv_a(0, 8'h00, 1, 0); step();

    // 4. flush beats a concurrent write
    drv_a(1, 8'h71, 0, 0); step();
    drv_a(1, 8'h72, 0, 0); step();
    drv_a(1, 8'h73, 0, 0); step();
    chk("fl.pre", 32'(fa.count), 3);
    drv_a(1, 8'h7F, 0, 1); step();
    chk_a_flags("fl", 0, 0, 0, 1, 1);
    chk("fl.ovf", 32'(fa.overflow), 0);
    chk("fl.unf", 32'(fa.underflow), 0);
    drv_a(0, 8'h00, 0, 0); step();
    chk("fl.drop", 32'(fa.count), 0);
    drv_a(1, 8'h80, 0, 0); step();
    chk("fl.rv", 32'(fa.read_value), 32'h80);
    chk("fl.cnt1", 32'(fa.count), 1);
    drv_a(0, 8'h00, 1, 0); step();
    drv_a(0, 8'h00, 0, 0); step();

    // 5a. random overlap, DEPTH=4
    q.delete(); pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 13 || popped < 13) && cyc < 400) begin
      w = (pushed < 13) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      v = 16'($urandom_range(0, 255));
      rd = r && (q.size() > 0);
      wr = w && (q.size() < 4 || rd);
      if (rd) chk("rnd_a.rv", 32'(fa.read_value), 32'(q[0]));
      drv_a(w, v[7:0], r, 0);
      step();
      if (rd) begin void'(q.pop_front()); popped++; end
      if (wr) begin q.push_back({8'h00, v[7:0]}); pushed++; end
      chk("rnd_a.count", 32'(fa.count), q.size());
      chk("rnd_a.af", 32'(fa.almost_full), 32'(q.size() >= 3));
      chk("rnd_a.ae", 32'(fa.almost_empty), 32'(q.size() <= 1));
      cyc++;
    end
    chk("rnd_a.done", 32'(cyc < 400), 1);
    drv_a(0, 8'h00, 0, 0);

    // 5b. random overlap, DEPTH=8, margins 2
    q.delete(); pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 25 || popped < 25) && cyc < 600) begin
      w = (pushed < 25) && ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 1) == 1);
      v = 16'($urandom_range(0, 65535));
      rd = r && (q.size() > 0);
      wr = w && (q.size() < 8 || rd);
      if (rd) chk("rnd_b.rv", 32'(fb.read_value), 32'(q[0]));
      fb.write = w; fb.write_value = v; fb.read = r; fb.flush = 0;
      step();
      if (rd) begin void'(q.pop_front()); popped++; end
      if (wr) begin q.push_back(v); pushed++; end
      chk("rnd_b.count", 32'(fb.count), q.size());
      chk("rnd_b.full", 32'(fb.full), 32'(q.size() == 8));
      chk("rnd_b.af", 32'(fb.almost_full), 32'(q.size() >= 6));
      chk("rnd_b.ae", 32'(fb.almost_empty), 32'(q.size() <= 2));
      cyc++;
    end
    chk("rnd_b.done", 32'(cyc < 600), 1);
    fb.write = 0; fb.read = 0;

    // 6. asynchronous reset between edges
    drv_a(1, 8'hA1, 0, 0); step();
    drv_a(1, 8'hA2, 0, 0); step();
    drv_a(0, 8'h00, 0, 0);
    chk("ar.pre", 32'(fa.count), 2);
    #2 res = 1'b1;
    #1;
    chk("ar.count", 32'(fa.count), 0);
    chk("ar.empty", 32'(fa.empty), 1);
    chk("ar.aempty", 32'(fa.almost_empty), 1);
    @(negedge clk) res = 1'b0;
    step();
    chk("ar.after", 32'(fa.empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
